// File: rtl/zvc_comp_ctrl.sv
// Job sequencer and credit-based flow controller for the 128-lane zero-value compressor.
// Optional statistics counters are built only when ZVC_CTRL_STATS_EN is defined.
module zvc_comp_ctrl #(
  parameter int WORD_WIDTH    = 8,
  parameter int DIST_WIDTH    = 7,
  parameter int MAX_LIFM_RSIZ = 4,
  parameter int PIPE_LAT      = 2,
  parameter int FIFO_DEPTH    = 4,
  parameter int CNT_WIDTH     = 16
) (
  input  logic                                   clk,
  input  logic                                   reset_n,
  input  logic                                   start,
  input  logic [CNT_WIDTH-1:0]                   job_lines,
  output logic                                   busy,
  output logic                                   done,
  input  logic                                   in_valid,
  output logic                                   in_ready,
  input  logic [128*WORD_WIDTH-1:0]              in_lifm,
  input  logic [128*DIST_WIDTH*MAX_LIFM_RSIZ-1:0] in_mt,
  output logic [128*WORD_WIDTH-1:0]              comp_lifm_line,
  output logic [128*DIST_WIDTH*MAX_LIFM_RSIZ-1:0] comp_mt_line,
  input  logic [128*WORD_WIDTH-1:0]              comp_lifm_comp,
  input  logic [128*DIST_WIDTH*MAX_LIFM_RSIZ-1:0] comp_mt_comp,
  output logic                                   out_valid,
  input  logic                                   out_ready,
  output logic [128*WORD_WIDTH-1:0]              out_lifm,
  output logic [128*DIST_WIDTH*MAX_LIFM_RSIZ-1:0] out_mt,
  output logic [7:0]                             out_nnz,
  output logic                                   out_last,
  output logic [31:0]                            stat_lines,
  output logic [31:0]                            stat_nnz
);
  localparam int LANES     = 128;
  localparam int LIFM_W    = LANES * WORD_WIDTH;
  localparam int LANE_MT_W = DIST_WIDTH * MAX_LIFM_RSIZ;
  localparam int MT_W      = LANES * LANE_MT_W;
  localparam int PTR_W     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int FCNT_W    = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_e;

  state_e               state_q, state_d;
  logic [CNT_WIDTH-1:0] job_q, job_d;
  logic [CNT_WIDTH-1:0] issued_q, issued_d;
  logic                 zero_done_q, zero_done_d;

  logic [PIPE_LAT-1:0]  pipe_vld_q;
  logic [PIPE_LAT-1:0]  pipe_last_q;
  logic [7:0]           pipe_nnz_q [PIPE_LAT];

  logic [LIFM_W-1:0]    fifo_lifm_q [FIFO_DEPTH];
  logic [MT_W-1:0]      fifo_mt_q   [FIFO_DEPTH];
  logic [7:0]           fifo_nnz_q  [FIFO_DEPTH];
  logic                 fifo_last_q [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr_q, rd_ptr_q;
  logic [FCNT_W-1:0]    fifo_cnt_q;

  logic       hs, hs_last, push, pop, head_last;
  logic [7:0] nnz_in, inflight;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // NOTE: every signal written in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    nnz_in   = '0;
    inflight = '0;
    for (int i = 0; i < LANES; i++) nnz_in = nnz_in + 8'(|in_mt[i*LANE_MT_W +: LANE_MT_W]);
    for (int i = 0; i < PIPE_LAT; i++) inflight = inflight + 8'(pipe_vld_q[i]);
  end

  // Credit counts only registered occupancy, so a same-cycle pop never frees a slot early.
  assign in_ready  = (state_q == S_RUN) && (issued_q < job_q) &&
                     ((int'(fifo_cnt_q) + int'(inflight)) < FIFO_DEPTH);
  assign hs        = in_valid && in_ready;
  assign hs_last   = hs && ((issued_q + 1'b1) == job_q);
  assign push      = pipe_vld_q[PIPE_LAT-1];
  assign out_valid = (fifo_cnt_q != '0);
  assign pop       = out_valid && out_ready;
  assign head_last = fifo_last_q[rd_ptr_q];

  assign comp_lifm_line = hs ? in_lifm : '0;
  assign comp_mt_line   = hs ? in_mt   : '0;

  assign out_lifm = out_valid ? fifo_lifm_q[rd_ptr_q] : '0;
  assign out_mt   = out_valid ? fifo_mt_q[rd_ptr_q]   : '0;
  assign out_nnz  = out_valid ? fifo_nnz_q[rd_ptr_q]  : '0;
  assign out_last = out_valid && head_last;

  assign busy = (state_q != S_IDLE);
  assign done = zero_done_q || ((state_q == S_DRAIN) && pop && head_last);

  always_comb begin
    state_d     = state_q;
    job_d       = job_q;
    issued_d    = issued_q;
    zero_done_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (job_lines != '0) begin
            job_d    = job_lines;
            issued_d = '0;
            state_d  = S_RUN;
          end else begin
            zero_done_d = 1'b1;
          end
        end
      end
      S_RUN: begin
        if (hs) begin
          issued_d = issued_q + 1'b1;
          if (hs_last) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (pop && head_last) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      job_q       <= '0;
      issued_q    <= '0;
      zero_done_q <= 1'b0;
      pipe_vld_q  <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      fifo_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      job_q       <= job_d;
      issued_q    <= issued_d;
      zero_done_q <= zero_done_d;
      for (int i = PIPE_LAT - 1; i > 0; i--) pipe_vld_q[i] <= pipe_vld_q[i-1];
      pipe_vld_q[0] <= hs;
      if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      case ({push, pop})
        2'b10:   fifo_cnt_q <= fifo_cnt_q + 1'b1;
        2'b01:   fifo_cnt_q <= fifo_cnt_q - 1'b1;
        default: fifo_cnt_q <= fifo_cnt_q;
      endcase
    end
  end

  // NOTE: storage arrays are left unreset; the valid bits and FIFO count decide what is visible.
  always_ff @(posedge clk) begin
    for (int i = PIPE_LAT - 1; i > 0; i--) begin
      pipe_nnz_q[i]  <= pipe_nnz_q[i-1];
      pipe_last_q[i] <= pipe_last_q[i-1];
    end
    pipe_nnz_q[0]  <= nnz_in;
    pipe_last_q[0] <= hs_last;
    if (push) begin
      fifo_lifm_q[wr_ptr_q] <= comp_lifm_comp;
      fifo_mt_q[wr_ptr_q]   <= comp_mt_comp;
      fifo_nnz_q[wr_ptr_q]  <= pipe_nnz_q[PIPE_LAT-1];
      fifo_last_q[wr_ptr_q] <= pipe_last_q[PIPE_LAT-1];
    end
  end

`ifdef ZVC_CTRL_STATS_EN
  logic [31:0] stat_lines_q, stat_nnz_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      stat_lines_q <= '0;
      stat_nnz_q   <= '0;
    end else if (pop) begin
      stat_lines_q <= stat_lines_q + 32'd1;
      stat_nnz_q   <= stat_nnz_q + 32'(out_nnz);
    end
  end

  assign stat_lines = stat_lines_q;
  assign stat_nnz   = stat_nnz_q;
`else
  assign stat_lines = '0;
  assign stat_nnz   = '0;
`endif

endmodule
